// File: rtl/gro_meas_ctrl_if.sv
// Result channel from gro_meas_ctrl to its consumer: one slot result per transfer.
// Latency: n/a (signal bundle only).
// Backpressure: the consumer stalls a result by holding ready low; the producer keeps every field stable.
// Ports: valid/ready handshake, sel = delay-line slot, count = captured 16-bit count,
//        err = count never settled to two equal consecutive samples.
interface gro_meas_ctrl_if;
   logic        valid;
   logic        ready;
   logic [2:0]  sel;
   logic [15:0] count;
   logic        err;

   modport master (output valid, output sel, output count, output err, input ready);
   modport slave  (input valid, input sel, input count, input err, output ready);
endinterface

// File: rtl/gro_meas_ctrl.sv
// Sweeps the enabled delay-line slots of a gated ring oscillator and reports one stable count per slot.
// Latency: per slot 2 clear + max(gate_cyc,1) gate + SETTLE_CYC settle + 2..MAX_TRY+1 sample + 1 out + 1 next cycles.
// Backpressure: a result waits in OUT with all fields frozen until res.ready; the sweep does not advance meanwhile.
// Ports: clk/rst (sync, active high); start/gate_cyc/dl_mask request a sweep; gro_en/gro_rstn/gro_sel
//        drive the oscillator and gro_count returns its ripple count; res carries results; busy/done report status.
module gro_meas_ctrl #(
   parameter int SETTLE_CYC = 8,
   parameter int MAX_TRY    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [15:0]     gate_cyc,
   input  logic [7:0]      dl_mask,
   output logic            gro_en,
   output logic            gro_rstn,
   output logic [2:0]      gro_sel,
   input  logic [15:0]     gro_count,
   gro_meas_ctrl_if.master res,
   output logic            busy,
   output logic            done
);
   localparam int          TRY_W       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
   localparam logic [15:0] SETTLE_LAST = (SETTLE_CYC > 1) ? 16'(SETTLE_CYC - 1) : 16'd0;

   typedef enum logic [2:0] {IDLE, CLR, GATE, SETTLE, SAMPLE, OUT, NEXT, FIN} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [15:0]        gate_len;
   logic [7:0]         mask;
   logic [2:0]         sel;
   logic [15:0]        tmr;
   logic [TRY_W-1:0]   tries;
   logic [15:0]        smp0;
   logic [15:0]        smp1;
   logic               smp_eq;
   logic               try_last;
   logic [2:0]         low_idx;
   logic [2:0]         up_idx;
   logic               up_any;
   logic               res_valid_q;
   logic [2:0]         res_sel_q;
   logic [15:0]        res_count_q;
   logic               res_err_q;
   logic               done_q;

   // smp0 is the first flop on the asynchronous count; smp1 holds the previous sample.
   assign smp_eq   = (smp0 == smp1);
   assign try_last = (tries == TRY_W'(MAX_TRY - 1));

   // Lowest set bit of the incoming mask, and next set bit strictly above the current slot.
   always_comb begin
      low_idx = 3'd0;
      up_idx  = 3'd0;
      up_any  = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (dl_mask[i]) begin
            low_idx = 3'(i);
         end
         if (mask[i] && (i > int'(sel))) begin
            up_idx = 3'(i);
            up_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (dl_mask == 8'd0) ? FIN : CLR;
         CLR:     if (tmr == 16'd1) state_nxt = GATE;
         GATE:    if (tmr == gate_len - 16'd1) state_nxt = SETTLE;
         SETTLE:  if (tmr == SETTLE_LAST) state_nxt = SAMPLE;
         // The first SAMPLE cycle only loads smp1; pairs are compared from the second cycle on.
         SAMPLE:  if ((tmr != 16'd0) && (smp_eq || try_last)) state_nxt = OUT;
         OUT:     if (res.ready) state_nxt = NEXT;
         NEXT:    state_nxt = up_any ? CLR : FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr         <= 16'd0;
         gate_len    <= 16'd1;
         mask        <= 8'd0;
         sel         <= 3'd0;
         tries       <= '0;
         smp0        <= 16'd0;
         smp1        <= 16'd0;
         gro_en      <= 1'b0;
         gro_rstn    <= 1'b0;
         res_valid_q <= 1'b0;
         res_sel_q   <= 3'd0;
         res_count_q <= 16'd0;
         res_err_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Timer restarts on every state change; each state measures its own dwell.
         tmr         <= (state_nxt != state) ? 16'd0 : tmr + 16'd1;
         // Oscillator controls are registered from the next state so they line up with it glitch-free.
         gro_en      <= (state_nxt == GATE);
         gro_rstn    <= (state_nxt != CLR);
         res_valid_q <= (state_nxt == OUT);
         done_q      <= (state == FIN);
         smp0        <= gro_count;

         if ((state == IDLE) && start) begin
            gate_len <= (gate_cyc == 16'd0) ? 16'd1 : gate_cyc;
            mask     <= dl_mask;
            if (dl_mask != 8'd0) sel <= low_idx;
         end
         // Slot select only moves here and in IDLE, so it is frozen from CLR through OUT.
         if ((state == NEXT) && up_any) sel <= up_idx;

         if (state == SAMPLE) begin
            smp1 <= smp0;
            if (tmr == 16'd0)  tries <= '0;
            else if (!smp_eq)  tries <= tries + TRY_W'(1);
            if (state_nxt == OUT) begin
               res_count_q <= smp0;
               res_err_q   <= !smp_eq;
               res_sel_q   <= sel;
            end
         end
      end
   end

   assign gro_sel   = sel;
   assign res.valid = res_valid_q;
   assign res.sel   = res_sel_q;
   assign res.count = res_count_q;
   assign res.err   = res_err_q;
   assign busy      = (state != IDLE);
   assign done      = done_q;
endmodule
